fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: address/instruction words and FSM states.
package fetch_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DISCARD,
    ST_FAULT
  } fetch_state_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: power-of-two circular FIFO with combinational head and synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push_i && !full && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Stale storage is masked so an empty buffer always presents zeros.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one-outstanding ROM requester feeding a prefetch FIFO, with redirect and fault.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_SIZE  = ADDR_W,
  parameter int INSTR_SIZE = INSTR_W,
  parameter int ROM_DEPTH  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  rom_req,
  output logic [ADDR_SIZE-1:0]  rom_addr,
  input  logic                  rom_valid,
  input  logic [INSTR_SIZE-1:0] rom_data,
  output logic                  instr_valid,
  output logic [INSTR_SIZE-1:0] instr,
  output logic [ADDR_SIZE-1:0]  instr_ip,
  input  logic                  instr_ready,
  input  logic                  jmp,
  input  logic [ADDR_SIZE-1:0]  jaddr,
  output logic                  fault
);

  localparam int EW = INSTR_SIZE + ADDR_SIZE;
  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]    DEPTH_M1  = CW'(FIFO_DEPTH - 1);
  localparam logic [ADDR_SIZE:0] ROM_LIMIT = (ADDR_SIZE + 1)'(ROM_DEPTH);

  fetch_state_t         state_q, state_d;
  logic [ADDR_SIZE-1:0] fetch_ip_q, fetch_ip_d;
  logic [ADDR_SIZE-1:0] req_addr_q, req_addr_d;
  logic                 in_range;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [EW-1:0]        fifo_head;
  logic                 push;

  assign in_range = ({1'b0, fetch_ip_q} < ROM_LIMIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      fetch_ip_q <= '0;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_ip_q <= fetch_ip_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_ip_d = fetch_ip_q;
    req_addr_d = req_addr_q;
    if (rom_req) begin
      fetch_ip_d = fetch_ip_q + 1'b1;
      req_addr_d = fetch_ip_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (rom_req)                                 state_d = ST_WAIT;
        else if (!jmp && fifo_empty && !in_range)    state_d = ST_FAULT;
      end
      ST_WAIT: begin
        // A redirect that coincides with the response has nothing left to drop.
        if (jmp)            state_d = rom_valid ? ST_IDLE : ST_DISCARD;
        else if (rom_valid) state_d = rom_req ? ST_WAIT : ST_IDLE;
      end
      ST_DISCARD: begin
        if (rom_valid) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (jmp) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (jmp) fetch_ip_d = jaddr;
  end

  // Issue thresholds reserve a slot for the in-flight response, so pushes never hit a full buffer.
  always_comb begin
    rom_req = 1'b0;
    push    = 1'b0;
    fault   = 1'b0;
    case (state_q)
      ST_IDLE:  rom_req = (fifo_count < DEPTH_C);
      ST_WAIT: begin
        rom_req = rom_valid && (fifo_count < DEPTH_M1);
        push    = rom_valid && !jmp;
      end
      ST_FAULT: fault = 1'b1;
      default:  ;
    endcase
    rom_req = rom_req && in_range && !jmp && rstn;
  end

  assign rom_addr = fetch_ip_q;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (jmp),
    .push_i  (push),
    .wdata_i ({rom_data, req_addr_q}),
    .pop_i   (instr_ready),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign instr_valid       = !fifo_empty;
  assign {instr, instr_ip} = fifo_head;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: behavioural ROM, expected-address queue and a delivery monitor.
module tb_fetch_unit;

  logic        clk;
  logic        rstn;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_valid;
  logic [31:0] rom_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [15:0] instr_ip;
  logic        instr_ready;
  logic        jmp;
  logic [15:0] jaddr;
  logic        fault;

  int          n_cmp = 0;
  int          n_err = 0;
  int          lat   = 1;
  logic [15:0] exp_q   [$];
  logic [15:0] req_log [$];

  fetch_unit #(
    .ADDR_SIZE  (16),
    .INSTR_SIZE (32),
    .ROM_DEPTH  (128),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_valid   (rom_valid),
    .rom_data    (rom_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ip    (instr_ip),
    .instr_ready (instr_ready),
    .jmp         (jmp),
    .jaddr       (jaddr),
    .fault       (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return {a ^ 16'hBEEF, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) exp_q.push_back(16'(a));
  endtask

  task automatic drain(input string name, input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic reset_assert();
    @(negedge clk);
    rstn = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    req_log.delete();
  endtask

  // ROM: responds 'lat' cycles after a request; inputs change on the falling edge.
  initial begin
    logic        pend;
    logic [15:0] pend_addr;
    int          cnt;
    pend = 1'b0; pend_addr = '0; cnt = 0;
    rom_valid = 1'b0; rom_data = '0;
    forever begin
      @(negedge clk);
      rom_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          rom_valid = 1'b1;
          rom_data  = rom_word(pend_addr);
          pend      = 1'b0;
        end
      end
      #1;
      if (rom_req) begin
        chk("one_outstanding", pend, 0);
        pend      = 1'b1;
        pend_addr = rom_addr;
        cnt       = lat;
        req_log.push_back(rom_addr);
      end
    end
  end

  // Monitor: every accepted delivery is checked against the head of the expected queue.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rstn && instr_valid) chk("fault_while_valid", fault, 0);
      if (rstn && instr_valid && instr_ready && !jmp) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_instr_ip", instr_ip, 16'hFFFF);
        end else begin
          e = exp_q.pop_front();
          $display("deliver ip=%04h instr=%08h exp_ip=%04h", instr_ip, instr, e);
          chk("instr_ip", instr_ip, e);
          chk("instr", instr, rom_word(e));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, expected summary first");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    rstn = 1'b0; jmp = 1'b0; jaddr = '0; instr_ready = 1'b0; lat = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rom_req", rom_req, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_ip", instr_ip, 0);
    chk("rst_fault", fault, 0);

    // Streaming, latency 1, decoder always ready
    @(negedge clk);
    req_log.delete();
    instr_ready = 1'b1;
    push_range(0, 9);
    rstn = 1'b1;
    #2;
    chk("first_req", rom_req, 1);
    chk("first_addr", rom_addr, 0);
    @(negedge clk); #2;
    chk("cycle2_valid", instr_valid, 0);
    @(negedge clk); #2;
    chk("cycle3_valid", instr_valid, 1);
    chk("cycle3_ip", instr_ip, 0);
    drain("stream_drain", 60);
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) chk("stream_addr", (req_log.size() > i) ? req_log[i] : 16'hFFFF, i);

    // Back-pressure fills the buffer without overflow
    reset_assert();
    lat = 1; instr_ready = 1'b0;
    rstn = 1'b1;
    repeat (15) @(negedge clk);
    #2;
    chk("full_req_count", req_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("full_addr", (req_log.size() > i) ? req_log[i] : 16'hFFFF, i);
    chk("full_rom_req", rom_req, 0);
    chk("full_head_ip", instr_ip, 0);
    @(negedge clk);
    push_range(0, 7);
    instr_ready = 1'b1;
    drain("full_drain", 60);
    instr_ready = 1'b0;

    // Redirect while the request for 5 is outstanding, latency 3
    reset_assert();
    lat = 3; instr_ready = 1'b1;
    push_range(0, 3);
    push_range(16'h40, 16'h45);
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #3;
      if (req_log.size() > 0 && req_log[req_log.size()-1] == 16'h5) break;
    end
    chk("req5_seen", (req_log.size() > 0) ? req_log[req_log.size()-1] : 16'hFFFF, 5);
    @(negedge clk);
    jmp = 1'b1; jaddr = 16'h40;
    @(negedge clk);
    jmp = 1'b0;
    drain("jmp_drain", 120);
    instr_ready = 1'b0;
    chk("jmp_req_count_ok", req_log.size() > 6, 1);
    chk("jmp_addr_after_5", (req_log.size() > 6) ? req_log[6] : 16'hFFFF, 16'h40);

    // Run off the end of ROM, fault, then recover with a redirect
    reset_assert();
    lat = 1; instr_ready = 1'b1;
    jmp = 1'b1; jaddr = 16'd120;
    push_range(120, 127);
    rstn = 1'b1;
    @(negedge clk);
    jmp = 1'b0;
    drain("edge_drain", 60);
    for (int i = 0; i < 10 && fault !== 1'b1; i++) @(negedge clk);
    #2;
    chk("fault_set", fault, 1);
    chk("fault_no_req", rom_req, 0);
    chk("last_req_127", (req_log.size() > 0) ? req_log[req_log.size()-1] : 16'hFFFF, 127);
    push_range(2, 7);
    @(negedge clk);
    jmp = 1'b1; jaddr = 16'd2;
    @(negedge clk);
    jmp = 1'b0;
    #2;
    chk("fault_cleared", fault, 0);
    chk("resume_req", rom_req, 1);
    chk("resume_addr", rom_addr, 2);
    drain("resume_drain", 60);
    instr_ready = 1'b0;

    // Asynchronous reset during an outstanding request
    reset_assert();
    lat = 3; instr_ready = 1'b0;
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #3;
      if (req_log.size() >= 3) break;
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("arst_rom_req", rom_req, 0);
    chk("arst_rom_addr", rom_addr, 0);
    chk("arst_instr_valid", instr_valid, 0);
    chk("arst_instr", instr, 0);
    chk("arst_instr_ip", instr_ip, 0);
    chk("arst_fault", fault, 0);
    repeat (6) @(negedge clk);
    #2;
    chk("arst_hold_req", rom_req, 0);
    chk("arst_hold_valid", instr_valid, 0);
    @(negedge clk);
    req_log.delete();
    lat = 1; instr_ready = 1'b1;
    push_range(0, 5);
    rstn = 1'b1;
    #2;
    chk("restart_req", rom_req, 1);
    chk("restart_addr", rom_addr, 0);
    drain("restart_drain", 60);
    instr_ready = 1'b0;

    // Redirect coinciding with a pop at count 3
    reset_assert();
    lat = 1; instr_ready = 1'b0;
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    exp_q.push_back(16'h0);
    instr_ready = 1'b1;
    @(negedge clk);
    jmp = 1'b1; jaddr = 16'h10;
    push_range(16'h10, 16'h13);
    @(negedge clk);
    jmp = 1'b0;
    #1;
    chk("flush_valid", instr_valid, 0);
    chk("flush_ip", instr_ip, 0);
    drain("flush_drain", 60);
    instr_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
